axis_adc_decimator: RTL and testbench
=====================================

# axis_adc_decimator

Boxcar decimator directly downstream of the Red Pitaya ADC AXI-Stream source. Consumes the continuous sign-extended sample stream (tvalid permanently high, no tready) and, after a trigger from the pulse sequencer, sums groups of `cfg_ratio` samples. It emits exactly `cfg_nsamples` decimated words on a handshaked AXI-Stream master toward the DMA/FIFO stage, with `tlast` on the final word. Samples arriving while the downstream is stalled are never back-pressured; lost results are flagged.

## Interface
Parameters:
- `AXIS_TDATA_WIDTH`, 32: input and output stream width.
- `SAMPLE_WIDTH`, 16: signed sample width taken from `s_axis_tdata[SAMPLE_WIDTH-1:0]`.
- `RATIO_WIDTH`, 16: width of the decimation ratio.
- `CNT_WIDTH`, 32: width of the output-sample count.

Ports (clock and reset first):
- `aclk`, in, 1: single clock for the whole block.
- `areset`, in, 1: synchronous reset, active-high.
- `cfg_ratio`, in, `RATIO_WIDTH`: input samples per output word; valid range 1..2^RATIO_WIDTH-1.
- `cfg_nsamples`, in, `CNT_WIDTH`: output words per acquisition.
- `cfg_shift`, in, 5: arithmetic right shift applied to each sum.
- `trig`, in, 1: acquisition start; level sampled each cycle.
- `s_axis_tvalid`, in, 1: input sample valid. No tready.
- `s_axis_tdata`, in, `AXIS_TDATA_WIDTH`: input sample.
- `m_axis_tvalid`, out, 1: output word valid.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis_tdata`, out, `AXIS_TDATA_WIDTH`: decimated word.
- `m_axis_tlast`, out, 1: marks word number `cfg_nsamples`.
- `sts_busy`, out, 1: high in ACQ and DRAIN.
- `sts_overrun`, out, 1: sticky; set when a result is dropped.
- `sts_count`, out, `CNT_WIDTH`: results produced (including dropped ones) in the current or last acquisition.

## Operation
- FSM states:
  - **IDLE**: waits for a trigger.
  - **ACQ**: accumulating.
  - **DRAIN**: final word pending.
- **IDLE → ACQ**: on `trig`=1 with `cfg_ratio`≠0 and `cfg_nsamples`≠0.
  - Latches `cfg_ratio`, `cfg_nsamples` and `cfg_shift`.
  - Clears the accumulator, phase counter, `sts_count` and `sts_overrun`.
  - Otherwise the FSM stays in IDLE.
- **Accumulation in ACQ**: each cycle with `s_axis_tvalid`=1 adds the sample, sign-extended to 32 bits, to the accumulator and increments the phase counter. The first sample accumulated is the one valid in the cycle after the trigger cycle.
- **Group completion**: when phase equals ratio−1, result = (acc + sample) >>> shift.
  - Accumulator and phase reset to 0.
  - `sts_count` increments.
- **Output register** (one deep):
  - A result loads it if it is empty, or if it is being accepted in the same cycle (`m_axis_tvalid` & `m_axis_tready`).
  - Otherwise the result is dropped and `sts_overrun` is set.
- **Final result**: the result where `sts_count` reaches `cfg_nsamples`.
  - If loaded, it carries `tlast`=1.
  - FSM → DRAIN, or → IDLE directly if that result was dropped.
- **DRAIN → IDLE**: on `m_axis_tvalid` & `m_axis_tready`.
- `trig` is ignored in ACQ and DRAIN. Config changes mid-acquisition have no effect.
- **Width rule**: the 32-bit accumulator cannot overflow for `SAMPLE_WIDTH`=16 and `RATIO_WIDTH`=16. `cfg_shift` values above 31 saturate to 31.

## Timing
- **Reset values**: all outputs 0, FSM in IDLE. `areset` mid-acquisition aborts immediately with no `tlast` emitted.
- **Latency**: the last sample of a group is valid at edge t, and `m_axis_tvalid` is high from edge t+1.
- **Output stability**: `m_axis_tdata` and `m_axis_tlast` are held stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.
- **Ratio 1**: one result per valid input cycle, so full throughput requires `m_axis_tready` continuously high.
- **`sts_busy`**: rises at edge t+1 after the trigger cycle. It falls at the edge after the final handshake, or after the final (dropped) result.

## Configuration
- **`AXIS_ADC_DECIM_ROUND_EN` defined**: shift rounds half-up, i.e. (sum + 2^(shift−1)) >>> shift when shift>0.
- **Not defined**: plain truncating arithmetic shift (round toward −∞).
- Shift=0 gives identical behaviour either way.

## Structure
- **Package `axis_adc_decim_pkg`**:
  - FSM state enum (IDLE, ACQ, DRAIN).
  - Accumulator width constant (32).
  - Shift-saturation constant (31).
- **Sub-module `axis_adc_decim_acc`**: accumulator, phase counter and shift/round logic. It outputs `result` and `result_strobe`.
- **Top level**: FSM, output register, counters and status.

## Test plan
- **Basic decimation**: ratio=4, nsamples=3, shift=0; inputs 1,2,3,… continuous, tready=1.
  - Expect outputs 10, 26, 42, with `tlast` only on 42.
  - `sts_count`=3, then IDLE.
- **Negative inputs with shift**: ratio=2, shift=1; inputs −3,−4 (0xFFFD,0xFFFC) then 5,6.
  - Without the macro: −4, 5.
  - With `AXIS_ADC_DECIM_ROUND_EN`: −3, 6.
- **Overrun**: ratio=1, nsamples=5; inputs 0..4 continuous; tready=0 for 3 cycles after the first valid word.
  - Words 1–3 are dropped and `sts_overrun`=1.
  - Output shows 0 then 4(`tlast`); `sts_count`=5.
- **Back-pressure in DRAIN**: ratio=2, nsamples=1; tready=0 for 10 cycles.
  - tdata/tlast held stable and `sts_busy`=1.
  - Handshake on tready; IDLE next cycle.
- **Reset and re-trigger**: reset mid-ACQ, then check the following.
  - All outputs 0.
  - A `trig` during a running acquisition is ignored (count unaffected).
  - A trig with ratio=0 stays in IDLE.
  - A retrigger after reset restarts cleanly with the correct first sum.

Source files
------------

// File: rtl/axis_adc_decim_pkg.sv
// Shared types and constants for the ADC boxcar decimator.
// No logic, so there is no latency and no backpressure.
// Holds the FSM state encoding, the accumulator width and the shift saturation helper.
package axis_adc_decim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int ACC_WIDTH = 32;
    localparam int SHIFT_MAX = 31;

    function automatic logic [4:0] sat_shift(input logic [4:0] s);
        return (int'(s) > SHIFT_MAX) ? 5'(SHIFT_MAX) : s;
    endfunction

endpackage

// File: rtl/axis_adc_decim_acc.sv
// Boxcar accumulator with phase counter and output shift. AXIS_ADC_DECIM_ROUND_EN selects round-half-up.
// The result is combinational in the cycle that carries the last sample of a group.
// There is no backpressure: every enabled cycle is consumed.
module axis_adc_decim_acc
    import axis_adc_decim_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int RATIO_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    i_start,
    input  logic                    i_en,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    input  logic [RATIO_WIDTH-1:0]  i_ratio,
    input  logic [4:0]              i_shift,
    output logic [ACC_WIDTH-1:0]    result,
    output logic                    result_strobe
);

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic        [RATIO_WIDTH-1:0] r_phase;

    logic signed [ACC_WIDTH-1:0] w_sample_sx;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH:0]   w_biased;

    assign w_sample_sx   = {{(ACC_WIDTH-SAMPLE_WIDTH){i_sample[SAMPLE_WIDTH-1]}}, i_sample};
    assign w_sum         = r_acc + w_sample_sx;
    assign result_strobe = i_en && (r_phase == (i_ratio - RATIO_WIDTH'(1)));

    // One guard bit so that adding the rounding bias cannot wrap.
`ifdef AXIS_ADC_DECIM_ROUND_EN
    always_comb begin
        w_biased = {w_sum[ACC_WIDTH-1], w_sum};
        if (i_shift != 5'd0)
            w_biased = w_biased + ((ACC_WIDTH+1)'(1) << (i_shift - 5'd1));
    end
`else
    assign w_biased = {w_sum[ACC_WIDTH-1], w_sum};
`endif

    assign result = ACC_WIDTH'(w_biased >>> i_shift);

    always_ff @(posedge aclk) begin
        if (areset || i_start) begin
            r_acc   <= '0;
            r_phase <= '0;
        end else if (i_en) begin
            if (result_strobe) begin
                r_acc   <= '0;
                r_phase <= '0;
            end else begin
                r_acc   <= w_sum;
                r_phase <= r_phase + RATIO_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/axis_adc_decimator.sv
// Triggered boxcar decimator from the ADC stream to an AXI-Stream master. AXIS_ADC_DECIM_ROUND_EN selects round-half-up.
// Latency: a word is valid one cycle after the last sample of its group.
// Backpressure: the input is never stalled; a result that finds the one-deep output register full is dropped and flagged.
module axis_adc_decimator
    import axis_adc_decim_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int RATIO_WIDTH      = 16,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [RATIO_WIDTH-1:0]      cfg_ratio,
    input  logic [CNT_WIDTH-1:0]        cfg_nsamples,
    input  logic [4:0]                  cfg_shift,
    input  logic                        trig,
    input  logic                        s_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic                        sts_busy,
    output logic                        sts_overrun,
    output logic [CNT_WIDTH-1:0]        sts_count
);

    state_t                      r_state;
    logic [RATIO_WIDTH-1:0]      r_ratio;
    logic [CNT_WIDTH-1:0]        r_nsamples;
    logic [4:0]                  r_shift;
    logic [CNT_WIDTH-1:0]        r_count;
    logic                        r_overrun;
    logic                        r_tvalid;
    logic                        r_tlast;
    logic [AXIS_TDATA_WIDTH-1:0] r_tdata;

    logic                 w_start;
    logic                 w_en;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_final;
    logic                 w_strobe;
    logic [ACC_WIDTH-1:0] w_result;

    generate
        if (AXIS_TDATA_WIDTH > SAMPLE_WIDTH) begin : g_unused_hi
            logic w_unused_tdata_hi;
            assign w_unused_tdata_hi = ^s_axis_tdata[AXIS_TDATA_WIDTH-1:SAMPLE_WIDTH];
        end
    endgenerate

    assign w_start  = (r_state == ST_IDLE) && trig && (cfg_ratio != '0) && (cfg_nsamples != '0);
    assign w_en     = (r_state == ST_ACQ) && s_axis_tvalid;
    assign w_accept = r_tvalid && m_axis_tready;
    assign w_load   = w_strobe && (!r_tvalid || m_axis_tready);
    assign w_final  = w_strobe && ((r_count + CNT_WIDTH'(1)) == r_nsamples);

    axis_adc_decim_acc #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .RATIO_WIDTH  (RATIO_WIDTH)
    ) u_acc (
        .aclk          (aclk),
        .areset        (areset),
        .i_start       (w_start),
        .i_en          (w_en),
        .i_sample      (s_axis_tdata[SAMPLE_WIDTH-1:0]),
        .i_ratio       (r_ratio),
        .i_shift       (r_shift),
        .result        (w_result),
        .result_strobe (w_strobe)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= ST_IDLE;
            r_ratio    <= '0;
            r_nsamples <= '0;
            r_shift    <= '0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A non-final word may still be pending after a dropped final result.
                    if (w_accept) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                    end
                    if (w_start) begin
                        r_ratio    <= cfg_ratio;
                        r_nsamples <= cfg_nsamples;
                        r_shift    <= sat_shift(cfg_shift);
                        r_count    <= '0;
                        r_overrun  <= 1'b0;
                        r_state    <= ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (w_accept) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                    end
                    if (w_strobe) begin
                        r_count <= r_count + CNT_WIDTH'(1);
                        if (w_load) begin
                            r_tvalid <= 1'b1;
                            r_tdata  <= AXIS_TDATA_WIDTH'($signed(w_result));
                            r_tlast  <= w_final;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                        if (w_final)
                            r_state <= w_load ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (w_accept) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
    assign sts_busy      = (r_state != ST_IDLE);
    assign sts_overrun   = r_overrun;
    assign sts_count     = r_count;

endmodule

// File: tb/tb_axis_adc_decimator.sv
// Bench for axis_adc_decimator: directed scenarios plus randomized acquisitions against a group-sum reference model.
module tb_axis_adc_decimator;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] cfg_ratio;
    logic [31:0] cfg_nsamples;
    logic [4:0]  cfg_shift;
    logic        trig;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        sts_busy;
    logic        sts_overrun;
    logic [31:0] sts_count;

    always #5 aclk = ~aclk;

    axis_adc_decimator dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_ratio     (cfg_ratio),
        .cfg_nsamples  (cfg_nsamples),
        .cfg_shift     (cfg_shift),
        .trig          (trig),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .sts_busy      (sts_busy),
        .sts_overrun   (sts_overrun),
        .sts_count     (sts_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: samples of the open group, results as floor/round of the group sum.
    bit     m_busy, m_drain, m_ovr;
    bit     slot_vld, slot_last;
    longint slot_dat;
    longint m_ratio, m_nsamp, m_shift, m_count;
    longint grp[$];

    logic [31:0] got_d[$];
    bit          got_l[$];
    logic [31:0] exp_d[$];
    bit          exp_l[$];

    function automatic longint shr_round(input longint sum, input longint sh);
        longint v;
        v = sum;
`ifdef AXIS_ADC_DECIM_ROUND_EN
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
        return v >>> sh;
    endfunction

    task automatic model_edge();
        bit     accepted, can_load, fin;
        longint sum;
        if (areset) begin
            m_busy = 0; m_drain = 0; m_ovr = 0;
            slot_vld = 0; slot_last = 0; slot_dat = 0;
            m_count = 0;
            grp.delete();
            return;
        end
        accepted = slot_vld && m_axis_tready;
        if (!m_busy) begin
            if (accepted) slot_vld = 0;
            if (trig && cfg_ratio != 0 && cfg_nsamples != 0) begin
                m_ratio = cfg_ratio; m_nsamp = cfg_nsamples; m_shift = cfg_shift;
                grp.delete();
                m_count = 0; m_ovr = 0; m_busy = 1; m_drain = 0;
            end
        end else if (!m_drain) begin
            can_load = !slot_vld || m_axis_tready;
            if (accepted) slot_vld = 0;
            if (s_axis_tvalid) begin
                grp.push_back(longint'($signed(s_axis_tdata[15:0])));
                if (grp.size() == m_ratio) begin
                    sum = 0;
                    foreach (grp[i]) sum += grp[i];
                    grp.delete();
                    m_count++;
                    fin = (m_count == m_nsamp);
                    if (can_load) begin
                        slot_vld = 1; slot_dat = shr_round(sum, m_shift); slot_last = fin;
                    end else begin
                        m_ovr = 1;
                    end
                    if (fin) begin
                        if (can_load) m_drain = 1;
                        else m_busy = 0;
                    end
                end
            end
        end else if (accepted) begin
            slot_vld = 0; m_busy = 0; m_drain = 0;
        end
    endtask

    task automatic cyc(input bit t, input bit v, input logic [31:0] d, input bit r);
        trig = t; s_axis_tvalid = v; s_axis_tdata = d; m_axis_tready = r;
        if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
            got_d.push_back(m_axis_tdata);
            got_l.push_back(m_axis_tlast);
        end
        model_edge();
        @(posedge aclk);
        #1;
        chk_eq("tvalid", m_axis_tvalid, slot_vld);
        if (slot_vld) begin
            chk_eq("tdata", m_axis_tdata, slot_dat[31:0]);
            chk_eq("tlast", m_axis_tlast, slot_last);
        end
        chk_eq("busy", sts_busy, m_busy);
        chk_eq("overrun", sts_overrun, m_ovr);
        chk_eq("count", sts_count, m_count[31:0]);
    endtask

    task automatic chk_got(input string tag);
        chk_eq({tag, "_nwords"}, got_d.size(), exp_d.size());
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            chk_eq({tag, "_data"}, got_d[i], exp_d[i]);
            chk_eq({tag, "_last"}, got_l[i], exp_l[i]);
        end
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk_eq({tag, "_tdata"},  m_axis_tdata, 0);
        chk_eq({tag, "_tlast"},  m_axis_tlast, 0);
        chk_eq({tag, "_busy"},   sts_busy, 0);
        chk_eq({tag, "_ovr"},    sts_overrun, 0);
        chk_eq({tag, "_count"},  sts_count, 0);
    endtask

    task automatic setcfg(input int r, input int n, input int sh);
        cfg_ratio = 16'(r); cfg_nsamples = 32'(n); cfg_shift = 5'(sh);
    endtask

    initial begin
        areset = 1; trig = 0; s_axis_tvalid = 0; s_axis_tdata = 0; m_axis_tready = 0;
        setcfg(0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk_reset_outputs("reset");
        areset = 0;
        cyc(0, 1, 0, 1);

        // Basic decimation: sums of 1..4, 5..8, 9..12.
        setcfg(4, 3, 0);
        cyc(1, 1, 0, 1);
        for (int i = 1; i <= 16; i++) cyc(0, 1, 32'(i), 1);
        exp_d = '{32'd10, 32'd26, 32'd42}; exp_l = '{0, 0, 1};
        chk_got("basic");
        chk_eq("basic_count", sts_count, 3);
        chk_eq("basic_idle", sts_busy, 0);

        // Negative samples with an arithmetic shift of one.
        setcfg(2, 2, 1);
        cyc(1, 1, 0, 1);
        cyc(0, 1, 32'h0000FFFD, 1);
        cyc(0, 1, 32'h0000FFFC, 1);
        cyc(0, 1, 32'd5, 1);
        cyc(0, 1, 32'd6, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1);
`ifdef AXIS_ADC_DECIM_ROUND_EN
        exp_d = '{32'hFFFFFFFD, 32'd6};
`else
        exp_d = '{32'hFFFFFFFC, 32'd5};
`endif
        exp_l = '{0, 1};
        chk_got("neg_shift");

        // Overrun: results 1..3 hit a full output register.
        setcfg(1, 5, 0);
        cyc(1, 1, 0, 1);
        for (int i = 0; i <= 4; i++) cyc(0, 1, 32'(i), !(i >= 1 && i <= 3));
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'd99, 1);
        exp_d = '{32'd0, 32'd4}; exp_l = '{0, 1};
        chk_got("overrun");
        chk_eq("overrun_flag", sts_overrun, 1);
        chk_eq("overrun_count", sts_count, 5);

        // Back-pressure while draining the final word.
        setcfg(2, 1, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 32'd7, 0);
        cyc(0, 1, 32'd8, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 32'($urandom), 0);
            chk_eq("drain_hold_data", m_axis_tdata, 15);
            chk_eq("drain_hold_last", m_axis_tlast, 1);
            chk_eq("drain_hold_busy", sts_busy, 1);
        end
        cyc(0, 1, 0, 1);
        chk_eq("drain_idle", sts_busy, 0);
        exp_d = '{32'd15}; exp_l = '{1};
        chk_got("drain");

        // Reset in the middle of an acquisition.
        setcfg(3, 10, 0);
        cyc(1, 1, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 32'd50, 1);
        areset = 1;
        cyc(0, 1, 0, 1);
        chk_reset_outputs("midrst");
        areset = 0;
        got_d.delete(); got_l.delete();

        // Trigger and config changes during acquisition have no effect.
        setcfg(2, 4, 0);
        cyc(1, 1, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) setcfg(5, 1, 3);
            cyc(i == 3 || i == 6, 1, 32'(i), 1);
        end
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
        exp_d = '{32'd3, 32'd7, 32'd11, 32'd15}; exp_l = '{0, 0, 0, 1};
        chk_got("retrig_ignored");
        chk_eq("retrig_count", sts_count, 4);

        // Zero ratio never starts an acquisition.
        setcfg(0, 3, 0);
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 1);
        chk_eq("ratio0_idle", sts_busy, 0);

        // Reset mid-acquisition, then restart cleanly.
        setcfg(2, 3, 0);
        cyc(1, 1, 0, 1);
        cyc(0, 1, 32'd1000, 1);
        areset = 1;
        cyc(0, 1, 0, 1);
        areset = 0;
        got_d.delete(); got_l.delete();
        setcfg(3, 1, 2);
        cyc(1, 1, 32'd9999, 1);
        cyc(0, 1, 32'd100, 1);
        cyc(0, 1, 32'd200, 1);
        cyc(0, 1, 32'd300, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
        exp_d = '{32'd150}; exp_l = '{1};
        chk_got("restart");

        // Randomized acquisitions with random gaps, stalls and stray triggers.
        for (int a = 0; a < 25; a++) begin
            setcfg($urandom_range(1, 5), $urandom_range(1, 6), $urandom_range(0, 6));
            cyc(1, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
            for (int c = 0; c < 300 && m_busy; c++)
                cyc(m_busy && ($urandom_range(0, 7) == 0), $urandom_range(0, 4) != 0,
                    $urandom, $urandom_range(0, 3) != 0);
            chk_eq("rand_done", sts_busy, 0);
            for (int c = 0; c < 2; c++) cyc(0, 1, $urandom, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
